ecc_point_ctrl: RTL and testbench

Elliptic-curve point sequencer that sits directly upstream of the GFAU and acts as its control unit. It accepts an affine point operation (addition P+Q or doubling 2P) over y² = x³ + ax + b mod p. It decomposes the operation into a fixed micro-sequence of GFAU add/sub/mult/div requests and issues them one at a time over the GFAU handshake. It returns affine (x3, y3) or flags the point at infinity. The block does no field arithmetic itself; all field results come from the GFAU.

---
 rtl/ecc_pkg.sv | 14 +
 rtl/ecc_point_urom.sv | 40 ++++
 rtl/ecc_point_ctrl.sv | 95 +++++++++
 tb/tb_ecc_point_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared opcodes, register indices, states and micro-instruction type for the point sequencer
package ecc_pkg;
    typedef enum logic [1:0] {GF_ADD = 2'd0, GF_SUB = 2'd1, GF_MUL = 2'd2, GF_DIV = 2'd3} gf_op_e;
    localparam logic [3:0] R_X1 = 4'd0, R_Y1 = 4'd1, R_X2 = 4'd2, R_Y2 = 4'd3, R_A = 4'd4;
    localparam logic [3:0] R_T0 = 4'd5, R_T1 = 4'd6, R_LAM = 4'd7, R_X3 = 4'd8, R_Y3 = 4'd9;
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_DONE} state_e;
    typedef struct packed {
        gf_op_e     op;
        logic [3:0] src0;
        logic [3:0] src1;
        logic [3:0] dst;
        logic       last;
    } uinst_t;
endpackage

// File: rtl/ecc_point_urom.sv
// ecc_point_urom: combinational micro-ROM mapping (mode, step) to a GFAU micro-instruction
module ecc_point_urom
    import ecc_pkg::*;
(
    input  logic       mode,
    input  logic [3:0] step,
    output uinst_t     ui
);
    logic [3:0] hd, t, xq;
    always_comb begin
        hd = mode ? 4'd6 : 4'd3;
        t  = step - hd;
        xq = mode ? R_X1 : R_X2;
        ui = '{GF_ADD, R_T0, R_T0, R_T0, 1'b0};
        if (step < hd) begin
            case ({mode, step})
                5'h00: ui = '{GF_SUB, R_Y2, R_Y1, R_T0, 1'b0};
                5'h01: ui = '{GF_SUB, R_X2, R_X1, R_T1, 1'b0};
                5'h02: ui = '{GF_DIV, R_T0, R_T1, R_LAM, 1'b0};
                5'h10: ui = '{GF_MUL, R_X1, R_X1, R_T0, 1'b0};
                5'h11: ui = '{GF_ADD, R_T0, R_T0, R_T1, 1'b0};
                5'h12: ui = '{GF_ADD, R_T1, R_T0, R_T0, 1'b0};
                5'h13: ui = '{GF_ADD, R_T0, R_A, R_T0, 1'b0};
                5'h14: ui = '{GF_ADD, R_Y1, R_Y1, R_T1, 1'b0};
                5'h15: ui = '{GF_DIV, R_T0, R_T1, R_LAM, 1'b0};
                default: ;
            endcase
        end else begin
            case (t)
                4'd0: ui = '{GF_MUL, R_LAM, R_LAM, R_T0, 1'b0};
                4'd1: ui = '{GF_SUB, R_T0, R_X1, R_T0, 1'b0};
                4'd2: ui = '{GF_SUB, R_T0, xq, R_X3, 1'b0};
                4'd3: ui = '{GF_SUB, R_X1, R_X3, R_T1, 1'b0};
                4'd4: ui = '{GF_MUL, R_LAM, R_T1, R_T1, 1'b0};
                4'd5: ui = '{GF_SUB, R_T1, R_Y1, R_Y3, 1'b1};
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/ecc_point_ctrl.sv
// ecc_point_ctrl: sequences affine point add/double as GFAU micro-ops and returns (x3, y3) or infinity
module ecc_point_ctrl
    import ecc_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            start,
    input  logic            mode,
    input  logic [SIZE-1:0] x1,
    input  logic [SIZE-1:0] y1,
    input  logic [SIZE-1:0] x2,
    input  logic [SIZE-1:0] y2,
    input  logic [SIZE-1:0] a_coef,
    output logic [SIZE-1:0] x3,
    output logic [SIZE-1:0] y3,
    output logic            done,
    output logic            busy,
    output logic            inf,
    output logic [1:0]      gf_op,
    output logic [SIZE-1:0] gf_in_0,
    output logic [SIZE-1:0] gf_in_1,
    output logic            gf_start,
    input  logic [SIZE-1:0] gf_result,
    input  logic            gf_done
);
    state_e          state, state_n;
    logic [3:0]      step;
    logic            mode_r, inf_n, act;
    logic [SIZE-1:0] rf [10];
    uinst_t          ui;

    ecc_point_urom u_rom (.mode(mode_r), .step(step), .ui(ui));

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        inf_n   = 1'b0;
        case (state)
            S_IDLE:  if (start) state_n = S_CHECK;
            S_CHECK: begin
                inf_n   = mode_r ? (rf[R_Y1] == '0) : (rf[R_X1] == rf[R_X2]);
                state_n = inf_n ? S_DONE : S_ISSUE;
            end
            S_ISSUE: state_n = S_WAIT;
            S_WAIT:  if (gf_done) state_n = ui.last ? S_DONE : S_ISSUE;
            default: state_n = S_IDLE;
        endcase
    end

    // operands are read straight from the register file; nothing they depend on changes until gf_done
    assign act      = (state == S_ISSUE) || (state == S_WAIT);
    assign gf_start = state == S_ISSUE;
    assign busy     = state != S_IDLE;
    assign done     = state == S_DONE;
    assign gf_op    = act ? ui.op : GF_ADD;
    assign gf_in_0  = act ? rf[ui.src0] : '0;
    assign gf_in_1  = act ? rf[ui.src1] : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            step   <= '0;
            mode_r <= 1'b0;
            inf    <= 1'b0;
            x3     <= '0;
            y3     <= '0;
            for (int i = 0; i < 10; i++) rf[i] <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                mode_r   <= mode;
                rf[R_X1] <= x1;
                rf[R_Y1] <= y1;
                rf[R_X2] <= x2;
                rf[R_Y2] <= y2;
                rf[R_A]  <= a_coef;
            end
            if (state == S_CHECK) step <= '0;
            if (state == S_WAIT && gf_done) begin
                rf[ui.dst] <= gf_result;
                step       <= step + 4'd1;
            end
            // the final op always targets Y3, so its result is taken directly off the bus
            if (state_n == S_DONE) begin
                inf <= inf_n;
                x3  <= inf_n ? '0 : rf[R_X3];
                y3  <= inf_n ? '0 : gf_result;
            end
        end
    end
endmodule

// File: tb/tb_ecc_point_ctrl.sv
// tb_ecc_point_ctrl: directed checks of ecc_point_ctrl against a behavioural mod-97 GFAU
module tb_ecc_point_ctrl;
    logic        i_clk = 1'b0, i_rst = 1'b1, start = 1'b0, mode = 1'b0, inj = 1'b0;
    logic [31:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, a_coef = 32'd2;
    logic [31:0] x3, y3, gf_in_0, gf_in_1, m_res, m_a, m_b;
    logic [1:0]  gf_op, m_op;
    logic        done, busy, inf, gf_start, m_done, gf_done_w;
    int          m_cnt, total = 0, bad = 0;

    assign gf_done_w = m_done | inj;
    always #5 i_clk = ~i_clk;

    ecc_point_ctrl #(.SIZE(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .start(start), .mode(mode),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .a_coef(a_coef),
        .x3(x3), .y3(y3), .done(done), .busy(busy), .inf(inf),
        .gf_op(gf_op), .gf_in_0(gf_in_0), .gf_in_1(gf_in_1), .gf_start(gf_start),
        .gf_result(m_res), .gf_done(gf_done_w)
    );

    function automatic logic [31:0] fcalc(logic [1:0] op, logic [31:0] a, logic [31:0] b);
        longint r = 1;
        case (op)
            2'd0: return (a + b) % 97;
            2'd1: return (a + 97 - b) % 97;
            2'd2: return (a * b) % 97;
            default: begin
                for (int i = 0; i < 95; i++) r = (r * longint'(b)) % 97;
                return 32'((longint'(a) * r) % 97);
            end
        endcase
    endfunction

    function automatic int klat(logic [1:0] op);
        return op < 2'd2 ? 2 : (op == 2'd2 ? 34 : 40);
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (gf_start) begin
                m_cnt <= klat(gf_op) - 1;
                m_op  <= gf_op;
                m_a   <= gf_in_0;
                m_b   <= gf_in_1;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_res  <= fcalc(m_op, m_a, m_b);
                end
            end
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic idle_zero(string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".gf_start"}, gf_start, 0);
        check({tag, ".x3"}, x3, 0);
        check({tag, ".y3"}, y3, 0);
        check({tag, ".inf"}, inf, 0);
        check({tag, ".gf_op"}, gf_op, 0);
        check({tag, ".gf_in"}, gf_in_0 | gf_in_1, 0);
    endtask

    task automatic run(string tag, logic m, logic [31:0] a1, logic [31:0] b1, logic [31:0] a2,
                       logic [31:0] b2, logic [31:0] ex, logic [31:0] ey, logic ei, int elat,
                       int est, logic noise);
        int n, cnt;
        logic pend, stab;
        logic [65:0] sv;
        @(negedge i_clk);
        mode = m; x1 = a1; y1 = b1; x2 = a2; y2 = b2; start = 1'b1;
        @(negedge i_clk);
        start = 1'b0; n = 1; cnt = 0; pend = 1'b0; stab = 1'b0; sv = '0;
        check({tag, ".busy"}, busy, 1);
        while (!done && n < 1000) begin
            if (gf_start) begin
                cnt++; sv = {gf_op, gf_in_0, gf_in_1}; pend = 1'b1; stab = 1'b0;
            end else if (pend) begin
                if ({gf_op, gf_in_0, gf_in_1} !== sv) stab = 1'b1;
                if (gf_done_w) begin
                    check({tag, ".stable"}, stab, 0);
                    pend = 1'b0;
                end
            end
            start = noise && n == 3;
            mode  = (noise && n == 3) ? ~m : m;
            @(negedge i_clk);
            n++;
        end
        start = 1'b0; mode = m;
        check({tag, ".latency"}, n, elat);
        check({tag, ".x3"}, x3, ex);
        check({tag, ".y3"}, y3, ey);
        check({tag, ".inf"}, inf, ei);
        check({tag, ".starts"}, cnt, est);
        @(negedge i_clk);
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".busy_end"}, busy, 0);
        check({tag, ".x3_hold"}, x3, ex);
    endtask

    initial begin
        int n, cnt;
        repeat (2) @(negedge i_clk);
        idle_zero("reset");
        i_rst = 1'b0;
        run("dbl", 1'b1, 3, 6, 0, 0, 80, 10, 1'b0, 172, 12, 1'b0);
        run("add", 1'b0, 3, 6, 80, 10, 80, 87, 1'b0, 131, 9, 1'b0);
        run("addinf", 1'b0, 3, 6, 3, 91, 0, 0, 1'b1, 2, 0, 1'b0);
        run("dblinf", 1'b1, 5, 0, 0, 0, 0, 0, 1'b1, 2, 0, 1'b0);
        @(negedge i_clk);
        inj = 1'b1;
        @(negedge i_clk);
        inj = 1'b0;
        check("spur.busy", busy, 0);
        check("spur.done", done, 0);
        check("spur.gf_start", gf_start, 0);
        check("spur.inf", inf, 1);
        run("noisy", 1'b1, 3, 6, 7, 7, 80, 10, 1'b0, 172, 12, 1'b1);
        @(negedge i_clk);
        mode = 1'b1; x1 = 3; y1 = 6; start = 1'b1;
        @(negedge i_clk);
        start = 1'b0; n = 0;
        while (!(gf_op == 2'd3 && busy) && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        check("rst.reach_div", gf_op, 3);
        repeat (5) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        idle_zero("rst");
        cnt = 0;
        repeat (50) begin
            @(negedge i_clk);
            if (gf_start) cnt++;
        end
        check("rst.no_gf_start", cnt, 0);
        run("post", 1'b1, 3, 6, 0, 0, 80, 10, 1'b0, 172, 12, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
